uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing one UART transmitter.
REQ-002 Parameter TIMEOUT, default 200000, maximum clk cycles from tx_start to tx_done before abort.
REQ-003 clk  in  1  single clock; all state on posedge clk.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 req  in  NREQ  per-requester level request, held until its ack.
REQ-006 req_data  in  8*NREQ  byte for requester i on bits [8i+7:8i].
REQ-007 ack  out  NREQ  one-cycle completion pulse to the granted requester.
REQ-008 err  out  NREQ  one-cycle error pulse, coincident with ack, set on tx_err or timeout.
REQ-009 cfg_baud  in  17  baud rate, e.g. 57600.
REQ-010 cfg_length  in  4  data bits per frame; cfg_parity_type, cfg_parity_en, cfg_stop2  in  1 each.
REQ-011 tx_start  out  1  one-cycle start pulse to UART.
REQ-012 tx_data  out  8; baud out 17; length out 4; parity_type, parity_en, stop2 out 1 each; frame data and config to UART.
REQ-013 tx_done  in  1; tx_err  in  1  UART completion and error status.
REQ-014 busy  out  1; gnt_id  out  clog2(NREQ)  transaction-in-progress flag and current or last grantee.
REQ-015 timeout  out  1  one-cycle pulse when a frame is aborted by the watchdog.

Function
REQ-016 FSM states: IDLE, START, WAIT, DONE.
REQ-017 IDLE: if any req bit is set, pick the grantee round-robin, starting the search at last_gnt+1 mod NREQ.
REQ-018 IDLE, at grant: latch req_data[grantee] into tx_data, latch all cfg_* inputs into the UART config outputs, set gnt_id, then go to START.
REQ-019 START: assert tx_start for exactly one cycle, clear the watchdog counter, then go to WAIT.
REQ-020 Latency: req rising in IDLE -> tx_start high 1 cycle later.
REQ-021 WAIT: count cycles; tx_done high -> DONE, with err = tx_err sampled in that same cycle.
REQ-022 WAIT: counter reaches TIMEOUT-1 without tx_done -> DONE with err=1 and timeout=1.
REQ-023 tx_done and timeout in the same cycle: tx_done wins; err = tx_err and timeout=0.
REQ-024 DONE: pulse ack[gnt_id] (and err[gnt_id] if flagged) for one cycle, update last_gnt=gnt_id, return to IDLE.
REQ-025 The next grant is evaluated no earlier than the cycle after DONE.
REQ-026 busy=1 in START, WAIT and DONE; busy=0 in IDLE.
REQ-027 tx_data and the UART config outputs hold stable from grant until the next grant; cfg_* changes mid-frame are ignored.
REQ-028 req deasserted mid-transaction: the frame still completes and ack is still pulsed.
REQ-029 tx_done received outside WAIT is ignored.
REQ-030 Watchdog counter width is clog2(TIMEOUT)+1 bits; it saturates and never wraps.
REQ-031 Only one ack bit may be high in any cycle.

Reset
REQ-032 rst_n low: state=IDLE, last_gnt=NREQ-1 (so requester 0 has first priority), counter=0.
REQ-033 rst_n low outputs: tx_start=0, ack=0, err=0, busy=0, timeout=0, gnt_id=0, tx_data=0, baud=0, length=0, parity_type=0, parity_en=0, stop2=0.
REQ-034 Reset asserted mid-frame aborts immediately with no ack.
REQ-035 After release, operation restarts from IDLE on the first posedge clk with rst_n high.

Verification
REQ-036 req=0001, req_data[7:0]=AF, cfg 57600/8/par_en=1/par_type=1/stop2=0 -> tx_start 1 cycle later, tx_data=AF, baud=57600; tx_done -> ack=0001 and err=0000 for 1 cycle.
REQ-037 req=1111 held continuously -> grant order 0,1,2,3,0; exactly one tx_start per frame.
REQ-038 TIMEOUT=100, tx_done never returned -> at cycle 100 after tx_start: timeout=1, err[gnt]=1, ack[gnt]=1, then IDLE.
REQ-039 tx_done=1 with tx_err=1 -> err[gnt]=1 coincident with ack; timeout=0.
REQ-040 Mid-WAIT: cfg_baud changed to 9600 and req deasserted -> baud stays 57600, ack still pulses.
REQ-041 rst_n low during WAIT -> all outputs 0 immediately, no ack; after release, req=0010 is granted first when bit 0 is not requesting.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among NREQ requesters, with a per-frame watchdog.
// Latency: a request seen in IDLE produces tx_start one cycle later; ack/err pulse one cycle after tx_done or the watchdog expiry.
// Backpressure: requesters hold req until ack; a new grant is evaluated no earlier than the cycle after the ack pulse.
//
// Ports: req_i/req_data_i        per-requester level request and byte (byte i on [8i+7:8i])
//        cfg_*_i                 UART frame config, latched at grant
//        tx_*_o, baud_o, ...     frame byte, config and one-cycle start pulse toward the UART
//        tx_done_i/tx_err_i      UART completion and error status
//        ack_o/err_o/timeout_o   one-cycle completion, error and watchdog-abort pulses
//        busy_o/gnt_id_o         transaction in progress, current or last grantee
module uart_tx_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 200000
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NREQ-1:0]                 req_i,
    input  logic [8*NREQ-1:0]               req_data_i,
    output logic [NREQ-1:0]                 ack_o,
    output logic [NREQ-1:0]                 err_o,
    input  logic [16:0]                     cfg_baud_i,
    input  logic [3:0]                      cfg_length_i,
    input  logic                            cfg_parity_type_i,
    input  logic                            cfg_parity_en_i,
    input  logic                            cfg_stop2_i,
    output logic                            tx_start_o,
    output logic [7:0]                      tx_data_o,
    output logic [16:0]                     baud_o,
    output logic [3:0]                      length_o,
    output logic                            parity_type_o,
    output logic                            parity_en_o,
    output logic                            stop2_o,
    input  logic                            tx_done_i,
    input  logic                            tx_err_i,
    output logic                            busy_o,
    output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] gnt_id_o,
    output logic                            timeout_o
);
    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_DONE} state_t;

    state_t            state_q;
    logic [GW-1:0]     last_gnt_q;
    logic [GW-1:0]     gnt_id_q;
    logic [CW-1:0]     cnt_q;
    logic [CW-1:0]     cnt_d;
    logic              tx_start_q;
    logic              busy_q;
    logic              timeout_q;
    logic [NREQ-1:0]   ack_q;
    logic [NREQ-1:0]   err_q;
    logic [7:0]        tx_data_q;
    logic [16:0]       baud_q;
    logic [3:0]        length_q;
    logic              parity_type_q;
    logic              parity_en_q;
    logic              stop2_q;
    logic [NREQ-1:0]   gnt_oh;

    // Round-robin pick: the requester with the smallest distance after last_gnt wins.
    logic              pick_vld;
    logic [GW-1:0]     pick_id;
    logic [7:0]        pick_dat;
    int                best_off;
    int                off;

    always_comb begin
        pick_vld = 1'b0;
        pick_id  = '0;
        pick_dat = '0;
        best_off = NREQ;
        off      = 0;
        for (int j = 0; j < NREQ; j++) begin
            off = (j + NREQ - 1 - int'(last_gnt_q)) % NREQ;
            if (req_i[j] && (off < best_off)) begin
                best_off = off;
                pick_vld = 1'b1;
                pick_id  = GW'(j);
                pick_dat = req_data_i[8*j +: 8];
            end
        end
    end

    // Watchdog increment saturates so a very long wait can never wrap back below the limit.
    assign cnt_d  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    assign gnt_oh = NREQ'(1) << gnt_id_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            last_gnt_q    <= GW'(NREQ - 1);
            gnt_id_q      <= '0;
            cnt_q         <= '0;
            tx_start_q    <= 1'b0;
            busy_q        <= 1'b0;
            timeout_q     <= 1'b0;
            ack_q         <= '0;
            err_q         <= '0;
            tx_data_q     <= '0;
            baud_q        <= '0;
            length_q      <= '0;
            parity_type_q <= 1'b0;
            parity_en_q   <= 1'b0;
            stop2_q       <= 1'b0;
        end else begin
            tx_start_q <= 1'b0;
            ack_q      <= '0;
            err_q      <= '0;
            timeout_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    if (pick_vld) begin
                        gnt_id_q      <= pick_id;
                        tx_data_q     <= pick_dat;
                        baud_q        <= cfg_baud_i;
                        length_q      <= cfg_length_i;
                        parity_type_q <= cfg_parity_type_i;
                        parity_en_q   <= cfg_parity_en_i;
                        stop2_q       <= cfg_stop2_i;
                        tx_start_q    <= 1'b1;
                        busy_q        <= 1'b1;
                        state_q       <= S_START;
                    end
                end
                S_START: begin
                    cnt_q   <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    cnt_q <= cnt_d;
                    // tx_done has priority over a watchdog expiry in the same cycle.
                    if (tx_done_i) begin
                        ack_q   <= gnt_oh;
                        err_q   <= tx_err_i ? gnt_oh : '0;
                        state_q <= S_DONE;
                    end else if (cnt_d >= CNT_LAST) begin
                        ack_q     <= gnt_oh;
                        err_q     <= gnt_oh;
                        timeout_q <= 1'b1;
                        state_q   <= S_DONE;
                    end
                end
                S_DONE: begin
                    last_gnt_q <= gnt_id_q;
                    busy_q     <= 1'b0;
                    state_q    <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign tx_start_o    = tx_start_q;
    assign busy_o        = busy_q;
    assign timeout_o     = timeout_q;
    assign ack_o         = ack_q;
    assign err_o         = err_q;
    assign gnt_id_o      = gnt_id_q;
    assign tx_data_o     = tx_data_q;
    assign baud_o        = baud_q;
    assign length_o      = length_q;
    assign parity_type_o = parity_type_q;
    assign parity_en_o   = parity_en_q;
    assign stop2_o       = stop2_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomized traffic against a transaction-timeline model.
// Latency: model predicts tx_start, ack/err/timeout cycles exactly from grant time and UART response delay.
// Backpressure: requesters hold req until ack; the UART responder answers after a random delay or never.
module tb_uart_tx_arbiter;
    localparam int NREQ = 4;
    localparam int TO   = 100;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [NREQ-1:0]   req_i = '0;
    logic [8*NREQ-1:0] req_data_i = '0;
    logic [16:0]       cfg_baud_i = '0;
    logic [3:0]        cfg_length_i = '0;
    logic              cfg_parity_type_i = 1'b0;
    logic              cfg_parity_en_i = 1'b0;
    logic              cfg_stop2_i = 1'b0;
    logic              tx_done_i = 1'b0;
    logic              tx_err_i = 1'b0;
    logic [NREQ-1:0]   ack_o, err_o;
    logic              tx_start_o, parity_type_o, parity_en_o, stop2_o, busy_o, timeout_o;
    logic [7:0]        tx_data_o;
    logic [16:0]       baud_o;
    logic [3:0]        length_o;
    logic [1:0]        gnt_id_o;

    uart_tx_arbiter #(.NREQ(NREQ), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req_i), .req_data_i(req_data_i),
        .ack_o(ack_o), .err_o(err_o), .cfg_baud_i(cfg_baud_i), .cfg_length_i(cfg_length_i),
        .cfg_parity_type_i(cfg_parity_type_i), .cfg_parity_en_i(cfg_parity_en_i),
        .cfg_stop2_i(cfg_stop2_i), .tx_start_o(tx_start_o), .tx_data_o(tx_data_o),
        .baud_o(baud_o), .length_o(length_o), .parity_type_o(parity_type_o),
        .parity_en_o(parity_en_o), .stop2_o(stop2_o), .tx_done_i(tx_done_i),
        .tx_err_i(tx_err_i), .busy_o(busy_o), .gnt_id_o(gnt_id_o), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    logic [31:0] cfg_obs;
    logic [45:0] outs_all;
    assign cfg_obs  = {tx_data_o, baud_o, length_o, parity_type_o, parity_en_o, stop2_o};
    assign outs_all = {tx_start_o, ack_o, err_o, busy_o, tx_data_o, baud_o, length_o,
                       parity_type_o, parity_en_o, stop2_o, timeout_o, gnt_id_o};

    int chk_cnt = 0;
    int fail_cnt = 0;
    int n = 0;

    // Transaction-timeline model
    bit              m_busy, m_to, m_errv;
    int              m_start, m_end, m_g, m_m, m_last, m_free_at;
    logic            exp_start, exp_busy, exp_to;
    logic [NREQ-1:0] exp_ack, exp_err;
    logic [1:0]      exp_gnt;
    logic [31:0]     exp_cfg;
    int              mode, fix_m, fix_err;
    int              dut_log[$];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, n);
        end
    endtask

    function automatic int rr(input int last, input logic [NREQ-1:0] r);
        for (int k = 1; k <= NREQ; k++)
            if (r[(last + k) % NREQ]) return (last + k) % NREQ;
        return -1;
    endfunction

    // UART response delay in cycles after tx_start; 0 = never answers, 1 = answers too early (ignored).
    function automatic int pick_delay();
        int r;
        r = $urandom_range(0, 15);
        if (r == 0) return 0;
        if (r == 1) return 1;
        if (r == 2) return TO;
        if (r == 3) return TO - 1;
        return $urandom_range(2, 12);
    endfunction

    task automatic model_reset();
        m_busy = 0; m_to = 0; m_errv = 0; m_last = NREQ - 1; m_free_at = 1;
        m_start = 0; m_end = 0; m_g = 0; m_m = 0; n = 0;
        exp_start = 0; exp_busy = 0; exp_to = 0; exp_ack = '0; exp_err = '0;
        exp_gnt = '0; exp_cfg = '0;
    endtask

    task automatic model_update();
        exp_start = 0; exp_ack = '0; exp_err = '0; exp_to = 0;
        if (m_busy && n > m_end) begin
            m_busy = 0; m_last = m_g; m_free_at = m_end + 2;
        end
        if (!m_busy && n >= m_free_at && req_i != '0) begin
            m_g = rr(m_last, req_i);
            m_busy = 1; m_start = n; m_errv = 0; exp_start = 1;
            exp_gnt = 2'(m_g);
            exp_cfg = {req_data_i[8*m_g +: 8], cfg_baud_i, cfg_length_i,
                       cfg_parity_type_i, cfg_parity_en_i, cfg_stop2_i};
            m_m = (fix_m >= 0) ? fix_m : pick_delay();
            if (m_m >= 2 && m_m <= TO) begin m_end = n + m_m; m_to = 0; end
            else begin m_end = n + TO; m_to = 1; end
        end else if (m_busy && n == m_end) begin
            exp_ack = NREQ'(1) << m_g;
            exp_err = (m_to || m_errv) ? exp_ack : '0;
            exp_to  = m_to;
        end
        exp_busy = m_busy;
    endtask

    task automatic drive();
        tx_done_i = 1'b0;
        tx_err_i  = 1'($urandom_range(0, 1));
        if (m_busy && m_m != 0 && n + 1 == m_start + m_m) begin
            tx_done_i = 1'b1;
            if (fix_err >= 0) tx_err_i = 1'(fix_err);
            m_errv = tx_err_i;
        end else if (!m_busy && $urandom_range(0, 7) == 0) begin
            tx_done_i = 1'b1;
        end
        if (mode != 2) begin
            req_data_i        = 32'($urandom);
            cfg_baud_i        = 17'($urandom);
            cfg_length_i      = 4'($urandom);
            cfg_parity_type_i = 1'($urandom);
            cfg_parity_en_i   = 1'($urandom);
            cfg_stop2_i       = 1'($urandom);
            if (mode == 1) req_i = '1;
            else begin
                for (int i = 0; i < NREQ; i++) begin
                    if (exp_ack[i]) req_i[i] = ($urandom_range(0, 2) == 0);
                    else if (!req_i[i]) req_i[i] = ($urandom_range(0, 5) == 0);
                    else if (m_busy && i == m_g && $urandom_range(0, 31) == 0) req_i[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        n++;
        model_update();
        @(negedge clk);
        check_eq("tx_start", 64'(tx_start_o), 64'(exp_start));
        check_eq("busy", 64'(busy_o), 64'(exp_busy));
        check_eq("ack", 64'(ack_o), 64'(exp_ack));
        check_eq("err", 64'(err_o), 64'(exp_err));
        check_eq("timeout", 64'(timeout_o), 64'(exp_to));
        check_eq("gnt_id", 64'(gnt_id_o), 64'(exp_gnt));
        check_eq("frame_cfg", 64'(cfg_obs), 64'(exp_cfg));
        if (tx_start_o) dut_log.push_back(int'(gnt_id_o));
        drive();
    endtask

    task automatic apply_reset(input logic [NREQ-1:0] req_after);
        rst_n = 1'b0;
        tx_done_i = 1'b0;
        #1;
        check_eq("rst_outs_now", 64'(outs_all), 64'(0));
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_outs_held", 64'(outs_all), 64'(0));
        req_i = req_after;
        rst_n = 1'b1;
    endtask

    task automatic wait_start(output int c);
        c = -1;
        for (int k = 0; k < 20 && c < 0; k++) begin
            step();
            if (tx_start_o) c = n;
        end
        if (c < 0) check_eq("start_wait_expired", 64'(0), 64'(1));
    endtask

    task automatic wait_ack(output int c);
        c = -1;
        for (int k = 0; k < 300 && c < 0; k++) begin
            step();
            if (ack_o != '0) c = n;
        end
        if (c < 0) check_eq("ack_wait_expired", 64'(0), 64'(1));
    endtask

    initial begin
        int s, c;
        int exp_ord[5];
        exp_ord = '{0, 1, 2, 3, 0};
        mode = 2; fix_m = 5; fix_err = 0;
        model_reset();
        cfg_baud_i = 17'd57600; cfg_length_i = 4'd8;
        cfg_parity_en_i = 1'b1; cfg_parity_type_i = 1'b1; cfg_stop2_i = 1'b0;
        req_data_i = 32'h0000_00AF;
        #2;
        apply_reset(4'b0001);

        // Single frame from requester 0
        step();
        check_eq("d_start_lat", 64'(tx_start_o), 64'(1));
        check_eq("d_tx_data", 64'(tx_data_o), 64'(8'hAF));
        check_eq("d_baud", 64'(baud_o), 64'(17'd57600));
        wait_ack(c);
        check_eq("d_ack", 64'(ack_o), 64'(4'b0001));
        check_eq("d_err_clear", 64'(err_o), 64'(4'b0000));
        req_i = '0;
        step();
        check_eq("d_ack_one_cycle", 64'(ack_o), 64'(0));

        // UART reports an error
        req_i = 4'b0001; fix_m = 3; fix_err = 1;
        wait_start(s);
        wait_ack(c);
        check_eq("e_err", 64'(err_o), 64'(4'b0001));
        check_eq("e_no_timeout", 64'(timeout_o), 64'(0));
        req_i = '0;

        // UART never answers: watchdog abort
        req_i = 4'b0001; fix_m = 0; fix_err = -1;
        wait_start(s);
        wait_ack(c);
        check_eq("t_latency", 64'(c - s), 64'(TO));
        check_eq("t_timeout", 64'(timeout_o), 64'(1));
        check_eq("t_err", 64'(err_o), 64'(4'b0001));
        req_i = '0;

        // Config change and request drop mid-frame
        req_i = 4'b0001; fix_m = 10;
        wait_start(s);
        step(); step(); step();
        cfg_baud_i = 17'd9600;
        req_i = '0;
        wait_ack(c);
        check_eq("m_baud_held", 64'(baud_o), 64'(17'd57600));
        check_eq("m_ack", 64'(ack_o), 64'(4'b0001));

        // All requesters held: rotation order from reset
        mode = 1; fix_m = 4;
        apply_reset(4'b1111);
        dut_log.delete();
        for (int k = 0; k < 200 && dut_log.size() < 5; k++) step();
        check_eq("rr_len", 64'(dut_log.size() >= 5), 64'(1));
        for (int i = 0; i < 5 && i < dut_log.size(); i++)
            check_eq($sformatf("rr_order%0d", i), 64'(dut_log[i]), 64'(exp_ord[i]));

        // Reset during WAIT, then requester 1 first
        mode = 2; req_i = 4'b0001; fix_m = 0;
        wait_start(s);
        step(); step(); step(); step();
        check_eq("w_busy_before_rst", 64'(busy_o), 64'(1));
        fix_m = 3;
        apply_reset(4'b0010);
        step();
        check_eq("w_gnt_after_rst", 64'(gnt_id_o), 64'(1));
        check_eq("w_start_after_rst", 64'(tx_start_o), 64'(1));
        req_i = '0;
        wait_ack(c);
        check_eq("w_ack_after_rst", 64'(ack_o), 64'(4'b0010));

        // Randomized traffic
        mode = 0; fix_m = -1; fix_err = -1;
        repeat (5000) step();
        mode = 1;
        repeat (1500) step();

        $display("TB_RESULT checks=%0d failures=%0d", chk_cnt, fail_cnt);
        $finish;
    end
endmodule
